// File: rtl/alu_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pipe_if
//  Description : Handshake and decode bus between ID/EX control and the
//                pipelined ALU control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_ctrl_pipe_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [2:0]       aluop;
  logic [5:0]       func;
  logic             out_valid;
  logic [3:0]       alu_ctrl;
  logic             shift_op;
  logic             illegal;
  logic [CNT_W-1:0] illegal_count;

  // Upstream side: presents operations, observes decoded result
  modport master (
    output in_valid, stall, flush, aluop, func,
    input  out_valid, alu_ctrl, shift_op, illegal, illegal_count
  );

  // Decoder side
  modport slave (
    input  in_valid, stall, flush, aluop, func,
    output out_valid, alu_ctrl, shift_op, illegal, illegal_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pipe
//  Description : Pipelined ALU control decoder. Decodes ALUop/func into the
//                4-bit ALU select through DEPTH register stages with
//                valid/stall/flush handling and a saturating count of
//                retired illegal decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_pipe #(
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  alu_ctrl_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject unsupported pipeline depths at elaboration
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("alu_ctrl_pipe: DEPTH must be in the range 1..4");
    end
  endgenerate

  // Decoded stage-0 payload
  logic [3:0] dec_ctrl;
  logic       dec_shift;
  logic       dec_illegal;

  // Per-stage state; index DEPTH-1 is the stage facing the ALU
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] shf;
  logic [DEPTH-1:0] ill;
  logic [3:0]       ctrl [DEPTH];

  logic [CNT_W-1:0] count;
  logic             retire_illegal;

  // Combinational decode; every path assigns all outputs so nothing goes stale
  always_comb begin
    dec_ctrl    = 4'd0;
    dec_shift   = 1'b0;
    dec_illegal = 1'b0;
    case (bus.aluop)
      3'd0: begin
        case (bus.func)
          6'h20: dec_ctrl = 4'd0;                     // add
          6'h14: dec_ctrl = 4'd1;                     // and
          6'h21: dec_ctrl = 4'd0;                     // lwn
          6'h27: dec_ctrl = 4'd2;                     // nor
          6'h25: dec_ctrl = 4'd3;                     // or
          6'h2a: dec_ctrl = 4'd4;                     // slt
          6'h2b: dec_ctrl = 4'd5;                     // sltu
          6'h00: begin dec_ctrl = 4'd6; dec_shift = 1'b1; end  // sll
          6'h02: begin dec_ctrl = 4'd7; dec_shift = 1'b1; end  // srl
          6'h13: dec_ctrl = 4'd0;                     // swn
          6'h24: dec_ctrl = 4'd8;                     // sub
          default: dec_illegal = 1'b1;
        endcase
      end
      3'd1:    dec_ctrl = 4'd0;
      3'd2:    dec_ctrl = 4'd8;
      3'd3:    dec_ctrl = 4'd1;
      3'd4:    dec_ctrl = 4'd3;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Pipeline advance: reset clears everything, flush kills valids, stall holds
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      shf <= '0;
      ill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl[i] <= 4'd0;
      end
    end else if (bus.flush) begin
      vld <= '0;
    end else if (!bus.stall) begin
      vld[0]  <= bus.in_valid;
      shf[0]  <= dec_shift;
      ill[0]  <= dec_illegal;
      ctrl[0] <= dec_ctrl;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        shf[i]  <= shf[i-1];
        ill[i]  <= ill[i-1];
        ctrl[i] <= ctrl[i-1];
      end
    end
  end

  // An illegal entry is counted only on the edge where it actually leaves
  assign retire_illegal = vld[DEPTH-1] & ill[DEPTH-1] & ~bus.stall & ~bus.flush;

  // Saturating illegal-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (retire_illegal && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign bus.out_valid     = vld[DEPTH-1];
  assign bus.alu_ctrl      = ctrl[DEPTH-1];
  assign bus.shift_op      = shf[DEPTH-1];
  assign bus.illegal       = ill[DEPTH-1];
  assign bus.illegal_count = count;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_pipe
//  Description : Self-checking bench for alu_ctrl_pipe. Three instances
//                (DEPTH 1/2/3, the last with a 2-bit counter) share one
//                stimulus stream and are compared against a FIFO-style model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       stall;
  logic       flush;
  logic [2:0] aluop;
  logic [5:0] func;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_pipe_if #(.CNT_W(16)) if0 ();
  alu_ctrl_pipe_if #(.CNT_W(16)) if1 ();
  alu_ctrl_pipe_if #(.CNT_W(2))  if2 ();

  assign if0.in_valid = in_valid; assign if0.stall = stall; assign if0.flush = flush;
  assign if0.aluop = aluop;       assign if0.func = func;
  assign if1.in_valid = in_valid; assign if1.stall = stall; assign if1.flush = flush;
  assign if1.aluop = aluop;       assign if1.func = func;
  assign if2.in_valid = in_valid; assign if2.stall = stall; assign if2.flush = flush;
  assign if2.aluop = aluop;       assign if2.func = func;

  alu_ctrl_pipe #(.DEPTH(1), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  alu_ctrl_pipe #(.DEPTH(2), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  alu_ctrl_pipe #(.DEPTH(3), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Observed outputs gathered into arrays so instances can be looped over
  logic        ov  [3];
  logic        osh [3];
  logic        oil [3];
  logic [3:0]  oc  [3];
  logic [31:0] ocnt[3];

  assign ov[0] = if0.out_valid; assign osh[0] = if0.shift_op; assign oil[0] = if0.illegal;
  assign ov[1] = if1.out_valid; assign osh[1] = if1.shift_op; assign oil[1] = if1.illegal;
  assign ov[2] = if2.out_valid; assign osh[2] = if2.shift_op; assign oil[2] = if2.illegal;
  assign oc[0] = if0.alu_ctrl;  assign oc[1] = if1.alu_ctrl;  assign oc[2] = if2.alu_ctrl;
  assign ocnt[0] = {16'd0, if0.illegal_count};
  assign ocnt[1] = {16'd0, if1.illegal_count};
  assign ocnt[2] = {30'd0, if2.illegal_count};

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic       v;
    logic       known;   // payload defined (reset or loaded), not after flush
    logic [3:0] c;
    logic       s;
    logic       i;
  } ent_t;

  ent_t pipe [3][4];
  int   mcnt [3] = '{0, 0, 0};
  int   mmax [3] = '{65535, 65535, 3};
  int   dep  [3] = '{1, 2, 3};
  int   rtab [int];                               // legal R-type func -> select
  int   optab[8] = '{-1, 0, 8, 1, 3, -1, -1, -1}; // aluop -> select, -1 illegal
  logic [5:0] legal_funcs [11] =
    '{6'h20, 6'h14, 6'h21, 6'h27, 6'h25, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h13, 6'h24};

  function automatic ent_t model_decode(input logic v, input logic [2:0] op,
                                        input logic [5:0] fn);
    ent_t e;
    e = '{v: v, known: 1'b1, c: 4'd0, s: 1'b0, i: 1'b0};
    if (op == 3'd0) begin
      if (rtab.exists(int'(fn))) begin
        e.c = 4'(rtab[int'(fn)]);
        e.s = (fn == 6'h00) || (fn == 6'h02);
      end else begin
        e.i = 1'b1;
      end
    end else if (optab[op] >= 0) begin
      e.c = 4'(optab[op]);
    end else begin
      e.i = 1'b1;
    end
    return e;
  endfunction

  // Model: each instance is a fixed-length FIFO that advances unless stalled
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int s = 0; s < 4; s++) pipe[k][s] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        mcnt[k] = 0;
      end else if (flush) begin
        for (int s = 0; s < 4; s++) begin
          pipe[k][s].v     = 1'b0;
          pipe[k][s].known = 1'b0;
        end
      end else if (!stall) begin
        if (pipe[k][dep[k]-1].v && pipe[k][dep[k]-1].i && mcnt[k] < mmax[k])
          mcnt[k] = mcnt[k] + 1;
        for (int s = 3; s > 0; s--) pipe[k][s] = pipe[k][s-1];
        pipe[k][0] = model_decode(in_valid, aluop, func);
      end
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0d expected=%0d", nm, k, $time, act, exp);
    end
  endtask

  // Compare process: every instance, every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("out_valid", k, int'(ov[k]), int'(pipe[k][dep[k]-1].v));
        if (pipe[k][dep[k]-1].known) begin
          chk("alu_ctrl", k, int'(oc[k]),  int'(pipe[k][dep[k]-1].c));
          chk("shift_op", k, int'(osh[k]), int'(pipe[k][dep[k]-1].s));
          chk("illegal",  k, int'(oil[k]), int'(pipe[k][dep[k]-1].i));
        end
        chk("illegal_count", k, int'(ocnt[k]), mcnt[k]);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc(input logic v, input logic [2:0] op, input logic [5:0] fn,
                     input logic st, input logic fl);
    in_valid = v; aluop = op; func = fn; stall = st; flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rtab[6'h20] = 0; rtab[6'h14] = 1; rtab[6'h21] = 0; rtab[6'h27] = 2;
    rtab[6'h25] = 3; rtab[6'h2a] = 4; rtab[6'h2b] = 5; rtab[6'h00] = 6;
    rtab[6'h02] = 7; rtab[6'h13] = 0; rtab[6'h24] = 8;

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; aluop = 3'd0; func = 6'd0;
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", k, int'(ov[k]), 0);
      chk("rst_alu_ctrl",  k, int'(oc[k]), 0);
      chk("rst_count",     k, int'(ocnt[k]), 0);
    end
    rst = 1'b0;

    // Back-to-back sll, sub, or, slt: latency equals DEPTH
    cyc(1'b1, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("d1_sll_ctrl", 0, int'(oc[0]), 6);
    chk("d1_sll_shift", 0, int'(osh[0]), 1);
    chk("d3_early_valid", 2, int'(ov[2]), 0);
    cyc(1'b1, 3'd2, 6'h00, 1'b0, 1'b0);
    chk("d1_sub_ctrl", 0, int'(oc[0]), 8);
    chk("d3_early_valid", 2, int'(ov[2]), 0);
    cyc(1'b1, 3'd4, 6'h00, 1'b0, 1'b0);
    chk("d3_sll_valid", 2, int'(ov[2]), 1);
    chk("d3_sll_ctrl",  2, int'(oc[2]), 6);
    chk("d3_sll_shift", 2, int'(osh[2]), 1);
    chk("d1_or_ctrl",   0, int'(oc[0]), 3);
    cyc(1'b1, 3'd0, 6'h2a, 1'b0, 1'b0);
    chk("d3_sub_ctrl",  2, int'(oc[2]), 8);
    chk("d1_slt_ctrl",  0, int'(oc[0]), 4);
    chk("d1_slt_shift", 0, int'(osh[0]), 0);
    chk("d1_slt_ill",   0, int'(oil[0]), 0);
    cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("d3_or_ctrl", 2, int'(oc[2]), 3);
    repeat (3) cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);

    // Five illegal ops: 2-bit counter saturates at 3
    cyc(1'b1, 3'd6, 6'h00, 1'b0, 1'b0);
    chk("aluop6_ctrl", 0, int'(oc[0]), 0);
    chk("aluop6_ill",  0, int'(oil[0]), 1);
    repeat (4) cyc(1'b1, 3'd6, 6'h00, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("sat_count_d1", 0, int'(ocnt[0]), 5);
    chk("sat_count_d2", 1, int'(ocnt[1]), 5);
    chk("sat_count_d3", 2, int'(ocnt[2]), 3);

    // Illegal func held under stall for 5 cycles counts once
    cyc(1'b1, 3'd0, 6'h3f, 1'b0, 1'b0);
    chk("f3f_ill",  0, int'(oil[0]), 1);
    chk("f3f_ctrl", 0, int'(oc[0]), 0);
    repeat (5) begin
      cyc(1'b1, 3'd0, 6'h3f, 1'b1, 1'b0);
      chk("stall_hold_valid", 0, int'(ov[0]), 1);
      chk("stall_hold_count", 0, int'(ocnt[0]), 5);
    end
    cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("stall_release_count", 0, int'(ocnt[0]), 6);
    repeat (3) cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("stall_count_d2", 1, int'(ocnt[1]), 6);

    // Flush with stall while two illegal entries are in flight
    cyc(1'b1, 3'd6, 6'h00, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 6'h3f, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 6'h00, 1'b1, 1'b1);
    chk("flush_valid0", 1, int'(ov[1]), 0);
    cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("flush_valid1", 1, int'(ov[1]), 0);
    chk("flush_count_d2", 1, int'(ocnt[1]), 6);
    chk("flush_count_d1", 0, int'(ocnt[0]), 7);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] fn;
      rst = ($urandom_range(0, 199) == 0);
      fn = ($urandom_range(0, 9) < 7) ? legal_funcs[$urandom_range(0, 10)] : 6'($urandom);
      cyc(1'($urandom), 3'($urandom), fn,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end
    rst = 1'b0;
    repeat (4) cyc(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised, pipelined ALU control decoder. Successor to the single-register ALUop/func decoder.
- Sits between the ID/EX pipeline register and the ALU. Decodes the 3-bit ALUop and the 6-bit R-type func into the 4-bit ALU select.
- Adds: configurable pipeline depth, valid/stall/flush handshake, defined illegal-code handling, shift flag, saturating illegal-instruction counter.

Parameters:
- DEPTH, 1, number of pipeline register stages (legal 1..4)
- CNT_W, 16, width of the illegal-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  aluop/func valid this cycle
- stall  in  1  freeze all stages (hazard unit)
- flush  in  1  kill all in-flight entries (branch taken)
- aluop  in  3  ALU operation class from main control
- func  in  6  R-type func field
- out_valid  out  1  alu_ctrl valid at ALU input
- alu_ctrl  out  4  ALU select
- shift_op  out  1  1 for sll/srl (ALU takes shamt, operand rt)
- illegal  out  1  decoded code unsupported
- illegal_count  out  CNT_W  retired illegal decodes, saturating

Behaviour:
- Reset (rst=1 at posedge): every stage valid=0, alu_ctrl=0, shift_op=0, illegal=0. illegal_count=0. All outputs read 0 from the following cycle.
- Decode (combinational, at stage 0 input):
  - aluop 0 (R-type), by func:
    - 0x20 add -> 0
    - 0x14 and -> 1
    - 0x21 lwn -> 0
    - 0x27 nor -> 2
    - 0x25 or -> 3
    - 0x2a slt -> 4
    - 0x2b sltu -> 5
    - 0x00 sll -> 6, shift_op=1
    - 0x02 srl -> 7, shift_op=1
    - 0x13 swn -> 0
    - 0x24 sub -> 8
    - any other func -> alu_ctrl=0, illegal=1
  - aluop 1 -> 0 (add)
  - aluop 2 -> 8 (sub)
  - aluop 3 -> 1 (and)
  - aluop 4 -> 3 (or)
  - aluop 5..7 -> alu_ctrl=0, illegal=1
  - Outputs are never left holding a stale value on an unmatched code.
- Pipeline:
  - DEPTH register stages. Each stage holds {valid, alu_ctrl, shift_op, illegal}.
  - Latency is exactly DEPTH cycles from an accepted input to out_valid.
  - Outputs are driven from the last stage.
  - Stage 0 loads valid=in_valid; the payload loads regardless of in_valid.
- Stall (stall=1, flush=0): all stages hold their contents, including out_valid and payload. Input is not accepted; upstream must hold it.
- Flush (flush=1): all stage valid bits cleared on the next edge; payload is don't-care. The input presented in the flush cycle is discarded. flush has priority over stall.
- Simultaneous rst and flush: rst wins, and all payload fields are zeroed as well.
- Counter:
  - illegal_count increments by 1 on an edge where last-stage valid=1, illegal=1, stall=0 and flush=0. An entry counts once, when it leaves the last stage.
  - Saturates at 2^CNT_W-1; no wrap.
  - An entry held for N stall cycles counts once, on its release edge.
- Out-of-range DEPTH (0 or >4): compile-time error via generate-time check.

Test Plan:
- DEPTH=1, rst for 2 cycles then released; drive in_valid=1, aluop=0, func=0x2a -> next cycle out_valid=1, alu_ctrl=4, shift_op=0, illegal=0; outputs all 0 during and one cycle after rst.
- DEPTH=3, back-to-back aluop=0/func=0x00, aluop=2, aluop=4 -> alu_ctrl 6 (shift_op=1), 8, 3 on cycles 3, 4, 5 with out_valid=1; out_valid=0 on cycles 1–2.
- DEPTH=2, stream of 4 ops with stall=1 for 3 cycles mid-stream -> out_valid/alu_ctrl frozen for 3 cycles, then sequence resumes with no drop or duplication.
- DEPTH=2, flush=1 together with stall=1 while 2 entries in flight -> out_valid=0 for the next 2 cycles; illegal_count unchanged even if flushed entries were illegal.
- aluop=0/func=0x3f, then aluop=6 -> alu_ctrl=0, illegal=1 on both; illegal_count increments by 2. Entry held 5 cycles under stall counts once.
- CNT_W=2, 5 illegal ops retired -> illegal_count reads 1, 2, 3, 3, 3 (saturation).
